// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF->ID pipeline boundary.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam logic [PIPE_DATA_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] ins;
    logic [PIPE_DATA_W-1:0] pc_plus4;
  } if_id_entry_t;

  // Ceiling log2 usable in constant expressions; returns 1 for v <= 2.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipe_fifo_core.sv
// In-order storage ring with read/write pointers and an occupancy counter.
module pipe_fifo_core
  import pipe_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = clog2(DEPTH),
  parameter int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [W-1:0]     i_wdata,
  output logic [W-1:0]     o_rdata,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_decode_queue.sv
// IF->ID queue: valid/ready handshake, flush priority and NOP substitution
// around an in-order storage ring.
module fetch_decode_queue
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [DATA_W-1:0]   NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       ins_f,
  input  logic [DATA_W-1:0]       pc_plus4_f,
  input  logic                    valid_f,
  output logic                    ready_f,
  input  logic                    flush,
  input  logic                    stall_d,
  output logic [DATA_W-1:0]       ins_d,
  output logic [DATA_W-1:0]       pc_plus4_d,
  output logic                    valid_d,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * DATA_W;

  logic [CNT_W-1:0] w_count;
  logic [ENT_W-1:0] w_head;
  logic             w_ready;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;

  // Ready depends only on occupancy, so a full queue refuses even while popping.
  assign w_ready = (w_count != CNT_W'(DEPTH));
  assign w_valid = (w_count != '0);
  assign w_push  = valid_f & w_ready & ~flush;
  assign w_pop   = w_valid & ~stall_d & ~flush;

  pipe_fifo_core #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_wdata ({ins_f, pc_plus4_f}),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign ready_f    = w_ready;
  assign valid_d    = w_valid;
  assign count      = w_count;
  assign ins_d      = w_valid ? w_head[ENT_W-1:DATA_W] : NOP_WORD;
  assign pc_plus4_d = w_valid ? w_head[DATA_W-1:0]     : '0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench: DEPTH=2 and DEPTH=4 queues against a queue-based model.
module tb_fetch_decode_queue;
  import pipe_pkg::*;

  localparam logic [31:0] NOP4 = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins_f;
  logic [31:0] pc_plus4_f;
  logic        valid_f;
  logic        flush;
  logic        stall_d;

  logic        ready2, valid2, ready4, valid4;
  logic [31:0] ins2, pc2, ins4, pc4;
  logic [1:0]  count2;
  logic [2:0]  count4;

  int n_checks = 0;
  int n_errors = 0;

  if_id_entry_t q2[$];
  if_id_entry_t q4[$];

  always #5 clk = ~clk;

  fetch_decode_queue #(.DATA_W(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ins_f(ins_f), .pc_plus4_f(pc_plus4_f),
    .valid_f(valid_f), .ready_f(ready2), .flush(flush), .stall_d(stall_d),
    .ins_d(ins2), .pc_plus4_d(pc2), .valid_d(valid2), .count(count2)
  );

  fetch_decode_queue #(.DATA_W(32), .DEPTH(4), .NOP_WORD(NOP4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ins_f(ins_f), .pc_plus4_f(pc_plus4_f),
    .valid_f(valid_f), .ready_f(ready4), .flush(flush), .stall_d(stall_d),
    .ins_d(ins4), .pc_plus4_d(pc4), .valid_d(valid4), .count(count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare both DUTs with the model's current queue contents.
  task automatic compare_all();
    check("d2_count", 32'(count2), 32'(q2.size()));
    check("d2_valid", 32'(valid2), 32'(q2.size() != 0));
    check("d2_ready", 32'(ready2), 32'(q2.size() != 2));
    check("d2_ins",   ins2, (q2.size() != 0) ? q2[0].ins : 32'h0);
    check("d2_pc",    pc2,  (q2.size() != 0) ? q2[0].pc_plus4 : 32'h0);
    check("d4_count", 32'(count4), 32'(q4.size()));
    check("d4_valid", 32'(valid4), 32'(q4.size() != 0));
    check("d4_ready", 32'(ready4), 32'(q4.size() != 4));
    check("d4_ins",   ins4, (q4.size() != 0) ? q4[0].ins : NOP4);
    check("d4_pc",    pc4,  (q4.size() != 0) ? q4[0].pc_plus4 : 32'h0);
  endtask

  // Apply one cycle of inputs, advance the model, then compare.
  task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic st, input logic fl);
    if_id_entry_t e;
    bit p2, o2, p4, o4;
    rst_n = rst; valid_f = v; ins_f = ins; pc_plus4_f = pc; stall_d = st; flush = fl;
    @(posedge clk);
    e.ins = ins;
    e.pc_plus4 = pc;
    if (!rst || fl) begin
      q2.delete();
      q4.delete();
    end else begin
      p2 = v && (q2.size() != 2);
      o2 = (q2.size() != 0) && !st;
      p4 = v && (q4.size() != 4);
      o4 = (q4.size() != 0) && !st;
      if (o2) void'(q2.pop_front());
      if (p2) q2.push_back(e);
      if (o4) void'(q4.pop_front());
      if (p4) q4.push_back(e);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [31:0] ins, input logic st);
    step(1'b1, 1'b1, ins, ins + 32'd4, st, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid_f = 1'b0; ins_f = '0; pc_plus4_f = '0; stall_d = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Reset held with IF presenting an entry
    step(1'b0, 1'b1, 32'h1111_1111, 32'h4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h1111_1111, 32'h4, 1'b0, 1'b0);
    check("rst_count", 32'(count2), 32'd0);
    check("rst_valid", 32'(valid2), 32'd0);
    check("rst_ins",   ins2, 32'h0);
    check("rst_ready", 32'(ready2), 32'd1);
    check("rst_nop4",  ins4, NOP4);
    push(32'h2002_0005, 1'b0);
    check("first_push", ins2, 32'h2002_0005);
    idle();

    // Streaming, one cycle latency
    push(32'hA0, 1'b0); check("stream_a0", ins2, 32'hA0); check("stream_cnt0", 32'(count2), 32'd1);
    push(32'hA1, 1'b0); check("stream_a1", ins2, 32'hA1); check("stream_cnt1", 32'(count2), 32'd1);
    push(32'hA2, 1'b0); check("stream_a2", ins2, 32'hA2); check("stream_pc2", pc2, 32'hA6);
    idle();             check("stream_drain", 32'(valid2), 32'd0);

    // Stall fill: B2 held at IF while full
    push(32'hB0, 1'b1); check("stall_rdy0", 32'(ready2), 32'd1);
    push(32'hB1, 1'b1); check("stall_rdy1", 32'(ready2), 32'd0); check("stall_cnt", 32'(count2), 32'd2);
    push(32'hB2, 1'b1); check("stall_held", ins2, 32'hB0); check("stall_cnt2", 32'(count2), 32'd2);
    push(32'hB2, 1'b0); check("rel_b1", ins2, 32'hB1); check("rel_cnt", 32'(count2), 32'd1);
    push(32'hB2, 1'b0); check("rel_b2", ins2, 32'hB2);
    idle();             check("rel_empty", 32'(count2), 32'd0);

    // Flush with simultaneous push and pop
    push(32'hC0, 1'b1);
    push(32'hC1, 1'b1);
    step(1'b1, 1'b1, 32'hC2, 32'hC6, 1'b0, 1'b1);
    check("flush_cnt", 32'(count2), 32'd0);
    check("flush_valid", 32'(valid2), 32'd0);
    check("flush_nop", ins2, 32'h0);
    check("flush_nop4", ins4, NOP4);
    push(32'hD0, 1'b0); check("post_flush", ins2, 32'hD0);
    idle();

    // Full with pop: push refused, accepted next cycle
    push(32'hE0, 1'b1);
    push(32'hE1, 1'b1); check("full_rdy", 32'(ready2), 32'd0);
    push(32'hE2, 1'b0); check("full_pop_cnt", 32'(count2), 32'd1); check("full_pop_head", ins2, 32'hE1);
    push(32'hE2, 1'b1); check("full_acc_cnt", 32'(count2), 32'd2);
    idle();             check("full_e2", ins2, 32'hE2);
    idle();

    // Randomized traffic; exercises pointer wrap in both depths
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0), $urandom, $urandom,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
